// File: rtl/wb_encoder_ctrl_if.sv
// Wishbone slave bus bundle for wb_encoder_ctrl.
// Buses are numbered [0:C_WB_DWIDTH-1]; index C_WB_DWIDTH-1 is the LSB.
interface wb_encoder_ctrl_if #(
    parameter int C_WB_DWIDTH = 32
);
    logic                   wb_we_i;
    logic                   wb_cyc_i;
    logic                   wb_stb_i;
    logic                   wb_ack_o;
    logic [0:C_WB_DWIDTH-1] wb_data_i;
    logic [0:C_WB_DWIDTH-1] wb_data_o;
    logic [0:C_WB_DWIDTH-1] wb_addr_i;

    modport slave (
        input  wb_we_i, wb_cyc_i, wb_stb_i, wb_data_i, wb_addr_i,
        output wb_ack_o, wb_data_o
    );

    modport master (
        output wb_we_i, wb_cyc_i, wb_stb_i, wb_data_i, wb_addr_i,
        input  wb_ack_o, wb_data_o
    );
endinterface

// File: rtl/wb_encoder_ctrl.sv
// Wishbone-controlled quadrature encoder controller: synchronises A/B/Z,
// decodes steps into a position counter, measures speed per PERIOD window
// and raises a level interrupt from sticky status flags.
// Optional macro ENC_FILTER_EN inserts a per-bit stability filter of
// C_FILT_LEN clocks after the synchroniser.
module wb_encoder_ctrl #(
    parameter int C_WB_DWIDTH = 32,
    parameter int C_FILT_LEN  = 4
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    wb_encoder_ctrl_if.slave wb,
    output logic             irq_o,
    input  logic [2:0]       enc_data
);
    localparam int DW = C_WB_DWIDTH;

    // Reversed-numbering buses become value-preserving descending vectors.
    logic [DW-1:0] wdat, waddr;
    logic [2:0]    off;
    logic          unused_addr;
    assign wdat        = wb.wb_data_i;
    assign waddr       = wb.wb_addr_i;
    assign off         = waddr[4:2];
    assign unused_addr = ^{waddr[DW-1:5], waddr[1:0]};

    logic          ack_q, irq_q;
    logic [DW-1:0] rdat_q;
    logic [2:0]    sync1_q, sync2_q, prev_q;
    logic [6:0]    ctrl_q, ctrl_d;
    logic [2:0]    stat_q, stat_d;
    logic [DW-1:0] pos_q, pos_d, speed_q, speed_d, period_q, period_d;
    logic [DW-1:0] snap_q, snap_d, presc_q, presc_d;
    logic [2:0]    samp;

`ifdef ENC_FILTER_EN
    localparam int CW = $clog2(C_FILT_LEN + 1);
    logic [2:0]         filt_q;
    logic [2:0][CW-1:0] fcnt_q;

    // Stability filter: follow the raw bit only after C_FILT_LEN differing clocks.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            filt_q <= '0;
            fcnt_q <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (sync2_q[i] != filt_q[i]) begin
                    if (fcnt_q[i] == CW'(C_FILT_LEN - 1)) begin
                        filt_q[i] <= sync2_q[i];
                        fcnt_q[i] <= '0;
                    end else begin
                        fcnt_q[i] <= fcnt_q[i] + 1'b1;
                    end
                end else begin
                    fcnt_q[i] <= '0;
                end
            end
        end
    end
    assign samp = filt_q;
`else
    localparam int unused_filt_len = C_FILT_LEN;
    assign samp = sync2_q;
`endif

    // Position of an {A,B} code along the forward cycle 00,01,11,10.
    function automatic logic [1:0] gidx(input logic a, input logic b);
        return {a, a ^ b};
    endfunction

    logic [1:0]    dlt;
    logic [2:0]    ev;
    logic          acc, wr;
    logic [DW-1:0] rd;
    assign dlt = gidx(samp[0], samp[1]) - gidx(prev_q[0], prev_q[1]);

    // Decode, prescaler, register writes, status events and read mux.
    always_comb begin
        ctrl_d   = ctrl_q;
        stat_d   = stat_q;
        pos_d    = pos_q;
        speed_d  = speed_q;
        period_d = period_q;
        snap_d   = snap_q;
        presc_d  = presc_q;
        ev       = '0;
        rd       = '0;
        acc      = wb.wb_stb_i & wb.wb_cyc_i & ~ack_q;
        wr       = acc & wb.wb_we_i;

        if (ctrl_q[0]) begin
            if (dlt == 2'd2)      ev[1] = 1'b1;
            else if (dlt == 2'd1) pos_d = ctrl_q[1] ? pos_q - 1'b1 : pos_q + 1'b1;
            else if (dlt == 2'd3) pos_d = ctrl_q[1] ? pos_q + 1'b1 : pos_q - 1'b1;
            if (samp[2] & ~prev_q[2]) begin
                ev[0] = 1'b1;
                if (ctrl_q[2]) pos_d = '0;
            end
        end

        // A PERIOD write restarts the measurement window from the current POS.
        if (wr && off == 3'd4) begin
            period_d = wdat;
            presc_d  = '0;
            snap_d   = pos_q;
        end else if (ctrl_q[0] && period_q != '0) begin
            if (presc_q == period_q - 1'b1) begin
                speed_d = pos_q - snap_q;
                snap_d  = pos_q;
                ev[2]   = 1'b1;
                presc_d = '0;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end else begin
            presc_d = '0;
        end

        if (wr && off == 3'd0) ctrl_d = wdat[6:0] & 7'h77;
        if (wr && off == 3'd2) pos_d  = wdat;
        // Set events win over a same-cycle write-1-to-clear.
        stat_d = (stat_q & ~((wr && off == 3'd1) ? wdat[2:0] : 3'b000)) | ev;

        case (off)
            3'd0:    rd = DW'(ctrl_q);
            3'd1:    rd = DW'({samp, 5'b00000, stat_q});
            3'd2:    rd = pos_q;
            3'd3:    rd = speed_q;
            3'd4:    rd = period_q;
            default: rd = '0;
        endcase
    end

    // State registers, synchroniser, registered bus outputs and interrupt.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_q    <= 1'b0;
            rdat_q   <= '0;
            irq_q    <= 1'b0;
            sync1_q  <= '0;
            sync2_q  <= '0;
            prev_q   <= '0;
            ctrl_q   <= '0;
            stat_q   <= '0;
            pos_q    <= '0;
            speed_q  <= '0;
            period_q <= '0;
            snap_q   <= '0;
            presc_q  <= '0;
        end else begin
            ack_q    <= acc;
            rdat_q   <= acc ? rd : '0;
            irq_q    <= |(stat_q & ctrl_q[6:4]);
            sync1_q  <= enc_data;
            sync2_q  <= sync1_q;
            prev_q   <= samp;
            ctrl_q   <= ctrl_d;
            stat_q   <= stat_d;
            pos_q    <= pos_d;
            speed_q  <= speed_d;
            period_q <= period_d;
            snap_q   <= snap_d;
            presc_q  <= presc_d;
        end
    end

    assign wb.wb_ack_o  = ack_q;
    assign wb.wb_data_o = rdat_q;
    assign irq_o        = irq_q;
endmodule

// File: tb/tb_wb_encoder_ctrl.sv
// Self-checking bench for wb_encoder_ctrl (default build, no input filter).
module tb_wb_encoder_ctrl;
    localparam int DW = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       irq;
    logic [2:0] enc = 3'b000;
    logic       chk_on = 1'b0;
    int         n_pass = 0;
    int         n_total = 0;
    int         gi = 0;

    always #5 clk = ~clk;

    wb_encoder_ctrl_if #(.C_WB_DWIDTH(DW)) bus();

    wb_encoder_ctrl #(.C_WB_DWIDTH(DW), .C_FILT_LEN(4)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wb       (bus),
        .irq_o    (irq),
        .enc_data (enc)
    );

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endfunction

    // Forward quadrature cycle of {A,B}.
    function automatic logic [1:0] gcode(int i);
        case (i & 3)
            0:       return 2'b00;
            1:       return 2'b01;
            2:       return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    function automatic int gpos(logic [1:0] ab);
        for (int i = 0; i < 4; i++) if (gcode(i) == ab) return i;
        return 0;
    endfunction

    // ---------------- reference model ----------------
    logic [31:0] m_ctrl, m_pos, m_speed, m_period, m_snap, m_presc, m_rdata;
    logic [2:0]  m_stat, e1, e2, e3;
    logic        m_ack, m_irq;

    always @(posedge clk) begin : model
        logic [31:0] a, d, rdv, pos_n, spd_n, per_n, snap_n, pre_n, ctl_n;
        logic [2:0]  ev, off, clr;
        logic        acc, wr, en;
        int          dl, s;
        if (rst) begin
            m_ctrl <= 0; m_pos <= 0; m_speed <= 0; m_period <= 0; m_snap <= 0;
            m_presc <= 0; m_rdata <= 0; m_stat <= 0; m_ack <= 0; m_irq <= 0;
            e1 <= 0; e2 <= 0; e3 <= 0;
        end else begin
            a = bus.wb_addr_i; d = bus.wb_data_i; off = a[4:2];
            acc = bus.wb_stb_i & bus.wb_cyc_i & ~m_ack;
            wr  = acc & bus.wb_we_i;
            en  = m_ctrl[0];
            dl  = (gpos({e2[0], e2[1]}) - gpos({e3[0], e3[1]}) + 4) % 4;
            ev = 0; pos_n = m_pos; spd_n = m_speed; per_n = m_period;
            snap_n = m_snap; pre_n = m_presc; ctl_n = m_ctrl;
            if (en) begin
                if (dl == 2) ev[1] = 1'b1;
                else if (dl != 0) begin
                    s = (dl == 1) ? 1 : -1;
                    if (m_ctrl[1]) s = -s;
                    pos_n = m_pos + 32'(s);
                end
                if (e2[2] && !e3[2]) begin
                    ev[0] = 1'b1;
                    if (m_ctrl[2]) pos_n = 0;
                end
            end
            if (wr && off == 4) begin
                per_n = d; pre_n = 0; snap_n = m_pos;
            end else if (en && m_period != 0) begin
                if (m_presc + 1 == m_period) begin
                    spd_n = m_pos - m_snap; snap_n = m_pos; ev[2] = 1'b1; pre_n = 0;
                end else pre_n = m_presc + 1;
            end else pre_n = 0;
            if (wr && off == 0) ctl_n = d & 32'h77;
            if (wr && off == 2) pos_n = d;
            clr = (wr && off == 1) ? d[2:0] : 3'b000;
            case (off)
                0: rdv = m_ctrl;
                1: rdv = {21'b0, e2, 5'b0, m_stat};
                2: rdv = m_pos;
                3: rdv = m_speed;
                4: rdv = m_period;
                default: rdv = 0;
            endcase
            m_irq   <= |(m_stat & m_ctrl[6:4]);
            m_stat  <= (m_stat & ~clr) | ev;
            m_ack   <= acc;
            m_rdata <= acc ? rdv : 32'h0;
            m_ctrl <= ctl_n; m_pos <= pos_n; m_speed <= spd_n;
            m_period <= per_n; m_snap <= snap_n; m_presc <= pre_n;
            e3 <= e2; e2 <= e1; e1 <= enc;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("ack", {31'b0, bus.wb_ack_o}, {31'b0, m_ack});
            chk("irq", {31'b0, irq}, {31'b0, m_irq});
            if (m_ack) chk("rdata", bus.wb_data_o, m_rdata);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wb_acc(input logic we, input logic [31:0] addr, input logic [31:0] dat,
                          output logic [31:0] rd);
        int n;
        @(negedge clk);
        bus.wb_stb_i = 1'b1; bus.wb_cyc_i = 1'b1; bus.wb_we_i = we;
        bus.wb_addr_i = addr; bus.wb_data_i = dat;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.wb_ack_o && n < 4);
        chk("ack_latency", n, 1);
        rd = bus.wb_data_o;
        bus.wb_stb_i = 1'b0; bus.wb_cyc_i = 1'b0; bus.wb_we_i = 1'b0;
    endtask

    task automatic wb_wr(input logic [31:0] addr, input logic [31:0] dat);
        logic [31:0] rd;
        wb_acc(1'b1, addr, dat, rd);
    endtask

    task automatic rd_chk(string nm, input logic [31:0] addr, input logic [31:0] mask,
                          input logic [31:0] exp);
        logic [31:0] rd;
        wb_acc(1'b0, addr, 32'h0, rd);
        chk(nm, rd & mask, exp);
    endtask

    task automatic enc_put(input logic [1:0] ab, input logic z);
        @(negedge clk);
        enc = {z, ab[0], ab[1]};
        repeat (2) @(negedge clk);
    endtask

    task automatic steps(input int n, input int dir);
        for (int i = 0; i < n; i++) begin
            gi = (gi + dir) & 3;
            enc_put(gcode(gi), 1'b0);
        end
    endtask

    initial begin
        logic [2:0] o;
        bus.wb_stb_i = 0; bus.wb_cyc_i = 0; bus.wb_we_i = 0;
        bus.wb_addr_i = 0; bus.wb_data_i = 0;
        @(posedge clk);
        chk_on = 1'b1;
        // bus activity while reset is held
        repeat (8) begin
            @(negedge clk);
            bus.wb_stb_i = 1'($urandom); bus.wb_cyc_i = 1'($urandom);
            bus.wb_we_i = 1'($urandom); bus.wb_addr_i = $urandom; bus.wb_data_i = $urandom;
        end
        @(negedge clk);
        bus.wb_stb_i = 0; bus.wb_cyc_i = 0; bus.wb_we_i = 0; rst = 1'b0;
        for (int i = 0; i < 5; i++) rd_chk("reset_reg", 32'(i * 4), 32'hFFFF_FFFF, 32'h0);

        // counting
        wb_wr(32'h00, 32'h1);
        steps(8, 1);  rd_chk("pos_fwd8", 32'h08, 32'hFFFF_FFFF, 32'd8);
        steps(3, -1); rd_chk("pos_rev3", 32'h08, 32'hFFFF_FFFF, 32'd5);
        wb_wr(32'h00, 32'h3);
        steps(2, 1);  rd_chk("pos_inv2", 32'h08, 32'hFFFF_FFFF, 32'd3);

        // illegal transition
        wb_wr(32'h00, 32'h21);
        gi = (gi + 2) & 3; enc_put(gcode(gi), 1'b0);
        rd_chk("err_set", 32'h04, 32'h7, 32'h2);
        rd_chk("pos_after_err", 32'h08, 32'hFFFF_FFFF, 32'd3);
        chk("irq_err", {31'b0, irq}, 32'h1);
        wb_wr(32'h04, 32'h2);
        rd_chk("err_clr", 32'h04, 32'h7, 32'h0);
        @(negedge clk);
        chk("irq_clr", {31'b0, irq}, 32'h0);

        // speed windows
        wb_wr(32'h00, 32'h1);
        wb_wr(32'h10, 32'd100);
        steps(10, 1);
        repeat (80) @(negedge clk);
        rd_chk("speed_p10", 32'h0C, 32'hFFFF_FFFF, 32'd10);
        rd_chk("per_set", 32'h04, 32'h4, 32'h4);
        wb_wr(32'h04, 32'h4);
        steps(4, -1);
        repeat (90) @(negedge clk);
        rd_chk("speed_m4", 32'h0C, 32'hFFFF_FFFF, 32'hFFFF_FFFC);
        wb_wr(32'h10, 32'd0);

        // wrap and index clear
        wb_wr(32'h08, 32'hFFFF_FFFF);
        steps(1, 1);  rd_chk("pos_wrap", 32'h08, 32'hFFFF_FFFF, 32'h0);
        wb_wr(32'h00, 32'h5);
        gi = (gi + 1) & 3; enc_put(gcode(gi), 1'b1);
        enc_put(gcode(gi), 1'b0);
        rd_chk("pos_idxclr", 32'h08, 32'hFFFF_FFFF, 32'h0);
        rd_chk("idx_set", 32'h04, 32'h1, 32'h1);

        // 2-clock glitch on A
        wb_wr(32'h00, 32'h1);
        wb_wr(32'h04, 32'h7);
        @(negedge clk); enc = enc ^ 3'b001;
        repeat (2) @(negedge clk); enc = enc ^ 3'b001;
        repeat (6) @(negedge clk);
        rd_chk("pos_glitch", 32'h08, 32'hFFFF_FFFF, 32'h0);

        // random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            o = 3'($urandom_range(0, 7));
            bus.wb_stb_i  = 1'($urandom);
            bus.wb_cyc_i  = ($urandom % 4) != 0;
            bus.wb_we_i   = 1'($urandom);
            bus.wb_addr_i = ($urandom & ~32'h1C) | {27'b0, o, 2'b00};
            bus.wb_data_i = (o == 3'd4) ? 32'($urandom % 6) : $urandom;
            if ($urandom % 3 == 0) enc = 3'($urandom);
        end
        @(negedge clk);
        bus.wb_stb_i = 0; bus.wb_cyc_i = 0;
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
